// File: rtl/spi_cmd_sequencer_if.sv
// Bus bundle for spi_cmd_sequencer: host command/control side, the SPI-top
// strobe side, and the status outputs.
//
// Handshake semantics: cmd_wr, cmd_clr, start and abort are single-cycle
// requests sampled on every rising clk edge (there is no ready; a request
// the sequencer cannot honour is dropped, and for cmd_wr the drop is flagged
// on wr_err). trigger is a one-cycle strobe, and ep_dataout is valid in that
// cycle and holds afterwards. The SPI top answers with a one-cycle spi_done
// pulse, which only counts while the sequencer is waiting for it.
interface spi_cmd_sequencer_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          cmd_wr;
    logic [31:0]   cmd_din;
    logic          cmd_clr;
    logic          start;
    logic          abort;
    logic          spi_done;
    logic [31:0]   ep_dataout;
    logic          trigger;
    logic          busy;
    logic          seq_done;
    logic          timeout_err;
    logic          wr_err;
    logic [CW-1:0] cmd_count;
    logic [2:0]    state_dbg;

    modport master (
        output cmd_wr, cmd_din, cmd_clr, start, abort, spi_done,
        input  ep_dataout, trigger, busy, seq_done, timeout_err, wr_err,
               cmd_count, state_dbg
    );

    modport slave (
        input  cmd_wr, cmd_din, cmd_clr, start, abort, spi_done,
        output ep_dataout, trigger, busy, seq_done, timeout_err, wr_err,
               cmd_count, state_dbg
    );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: stores a list of 32-bit SPI command words and replays
// it to the SPI top on start. Data-transfer words (bit30) wait for spi_done
// with a timeout; all other words are followed by a fixed idle gap.
module spi_cmd_sequencer #(
    parameter int DEPTH          = 16,
    parameter int GAP_CYCLES     = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                clk,
    input logic                rst,
    spi_cmd_sequencer_if.slave bus
);
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // A zero gap would let two triggers touch, so the gap is at least one cycle.
    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int TMAX    = (TIMEOUT_CYCLES > GAP_EFF) ? TIMEOUT_CYCLES : GAP_EFF;
    localparam int TW      = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [IW-1:0]  index;
    logic [IW-1:0]  index_n;
    logic [TW-1:0]  timer;
    logic [TW-1:0]  timer_n;

    logic [31:0]    cmd_buf [DEPTH];

    logic [31:0]    ep_dataout_q, ep_dataout_n;
    logic           trigger_q, trigger_n;
    logic           busy_q, busy_n;
    logic           seq_done_q, seq_done_n;
    logic           timeout_q, timeout_n;
    logic           wr_err_q, wr_err_n;
    logic [CW-1:0]  count_q, count_n;

    logic           in_idle;
    logic           start_ok;
    logic           start_empty;
    logic           is_last;
    logic           wait_expired;
    logic           gap_over;
    logic           clr_ok;
    logic           wr_accept;
    logic           wr_reject;

    // Qualified requests and terminal-count conditions shared by both comb blocks.
    assign in_idle      = (state == S_IDLE);
    assign start_ok     = in_idle && bus.start && !bus.abort && (count_q != '0);
    assign start_empty  = in_idle && bus.start && !bus.abort && (count_q == '0);
    assign is_last      = (CW'(index) >= (count_q - CW'(1)));
    assign wait_expired = (timer == TW'(TIMEOUT_CYCLES - 1));
    assign gap_over     = (timer == TW'(GAP_EFF - 1));
    assign clr_ok       = in_idle && bus.cmd_clr;
    assign wr_accept    = in_idle && bus.cmd_wr && !bus.cmd_clr && (count_q < CW'(DEPTH));
    assign wr_reject    = bus.cmd_wr && !clr_ok && !wr_accept;

    // State register: sequencer position, list index and wait/gap timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            index <= '0;
            timer <= '0;
        end else begin
            state <= state_n;
            index <= index_n;
            timer <= timer_n;
        end
    end

    // Next state: issue each entry once, then wait for spi_done or sit out the gap.
    always_comb begin
        state_n = state;
        index_n = index;
        timer_n = timer;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_n = S_ISSUE;
                    index_n = '0;
                end
            end
            S_ISSUE: begin
                timer_n = '0;
                // ep_dataout_q already holds the word being issued this cycle.
                state_n = ep_dataout_q[30] ? S_WAIT : S_GAP;
            end
            S_WAIT: begin
                if (bus.spi_done) begin
                    if (is_last) begin
                        state_n = S_FINISH;
                    end else begin
                        state_n = S_ISSUE;
                        index_n = index + 1'b1;
                    end
                end else if (wait_expired) begin
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_over) begin
                    if (is_last) begin
                        state_n = S_FINISH;
                    end else begin
                        state_n = S_ISSUE;
                        index_n = index + 1'b1;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            S_FINISH: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        // Abort outranks start, spi_done and every in-flight step.
        if (bus.abort && (state != S_IDLE)) begin
            state_n = S_IDLE;
        end
    end

    // Output values for the next cycle, derived from the next state so every output is a flop.
    always_comb begin
        trigger_n    = (state_n == S_ISSUE);
        ep_dataout_n = trigger_n ? cmd_buf[index_n] : ep_dataout_q;
        busy_n       = (state_n != S_IDLE);
        seq_done_n   = (state_n == S_FINISH) || start_empty;

        timeout_n = timeout_q;
        if (start_ok) begin
            timeout_n = 1'b0;
        end
        if ((state == S_WAIT) && !bus.abort && !bus.spi_done && wait_expired) begin
            timeout_n = 1'b1;
        end

        wr_err_n = wr_err_q;
        if (clr_ok) begin
            wr_err_n = 1'b0;
        end else if (wr_reject) begin
            wr_err_n = 1'b1;
        end

        count_n = count_q;
        if (clr_ok) begin
            count_n = '0;
        end else if (wr_accept) begin
            count_n = count_q + 1'b1;
        end
    end

    // Output and entry-count registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ep_dataout_q <= '0;
            trigger_q    <= 1'b0;
            busy_q       <= 1'b0;
            seq_done_q   <= 1'b0;
            timeout_q    <= 1'b0;
            wr_err_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            ep_dataout_q <= ep_dataout_n;
            trigger_q    <= trigger_n;
            busy_q       <= busy_n;
            seq_done_q   <= seq_done_n;
            timeout_q    <= timeout_n;
            wr_err_q     <= wr_err_n;
            count_q      <= count_n;
        end
    end

    // Command storage; contents survive reset, only the count is cleared.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            cmd_buf[count_q[IW-1:0]] <= bus.cmd_din;
        end
    end

    assign bus.ep_dataout  = ep_dataout_q;
    assign bus.trigger     = trigger_q;
    assign bus.busy        = busy_q;
    assign bus.seq_done    = seq_done_q;
    assign bus.timeout_err = timeout_q;
    assign bus.wr_err      = wr_err_q;
    assign bus.cmd_count   = count_q;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: directed scenarios, a list-replay model checked
// every cycle, and literal expectations for the key timing points.
module tb_spi_cmd_sequencer;
    localparam int DEPTH = 16;
    localparam int GAP   = 3;
    localparam int TMO   = 1024;

    logic clk;
    logic rst;

    spi_cmd_sequencer_if #(.DEPTH(DEPTH)) bus();

    spi_cmd_sequencer #(
        .DEPTH(DEPTH),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;
    bit prev_trig = 0;

    // Words expected on trigger strobes, in order.
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The stored list is a queue; a running replay is tracked as a position
    // plus either a gap countdown or the age of the current wait.
    logic [31:0] m_list[$];
    bit          m_run, m_issue, m_wait, m_finish;
    int          m_pos, m_gap_left, m_age;
    bit          was_idle;
    int          old_size;
    logic [31:0] e_ep;
    logic        e_trig, e_busy, e_done, e_tmo, e_werr;

    task automatic m_issue_entry(input int p);
        m_pos   = p;
        m_issue = 1;
        e_trig  = 1;
        e_ep    = m_list[p];
    endtask

    task automatic m_next();
        m_wait = 0;
        if (m_pos + 1 < m_list.size()) begin
            m_issue_entry(m_pos + 1);
        end else begin
            m_finish = 1;
            e_done   = 1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_list.delete();
            m_run = 0; m_issue = 0; m_wait = 0; m_finish = 0;
            m_pos = 0; m_gap_left = 0; m_age = 0;
            e_ep = '0; e_trig = 0; e_busy = 0; e_done = 0; e_tmo = 0; e_werr = 0;
        end else begin
            was_idle = !m_run;
            old_size = m_list.size();
            e_trig = 0;
            e_done = 0;
            if (was_idle) begin
                if (bus.start && !bus.abort) begin
                    if (old_size == 0) begin
                        e_done = 1;
                    end else begin
                        m_run = 1;
                        e_tmo = 0;
                        m_issue_entry(0);
                    end
                end
            end else if (bus.abort) begin
                m_run = 0; m_issue = 0; m_wait = 0; m_finish = 0;
            end else if (m_finish) begin
                m_run = 0;
                m_finish = 0;
            end else if (m_issue) begin
                m_issue = 0;
                if (e_ep[30]) begin
                    m_wait = 1;
                    m_age  = 0;
                end else begin
                    m_gap_left = GAP;
                end
            end else if (m_wait) begin
                m_age++;
                if (bus.spi_done) begin
                    m_next();
                end else if (m_age == TMO) begin
                    m_wait = 0;
                    m_run  = 0;
                    e_tmo  = 1;
                end
            end else begin
                m_gap_left--;
                if (m_gap_left == 0) m_next();
            end
            if (was_idle && bus.cmd_clr) begin
                m_list.delete();
                e_werr = 0;
            end else if (bus.cmd_wr) begin
                if (was_idle && m_list.size() < DEPTH) m_list.push_back(bus.cmd_din);
                else e_werr = 1;
            end
            e_busy = m_run;
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            check("trigger", bus.trigger, e_trig);
            check("ep_dataout", bus.ep_dataout, e_ep);
            check("busy", bus.busy, e_busy);
            check("seq_done", bus.seq_done, e_done);
            check("timeout_err", bus.timeout_err, e_tmo);
            check("wr_err", bus.wr_err, e_werr);
            check("cmd_count", bus.cmd_count, m_list.size());
            check("trigger_not_back_to_back", bus.trigger & prev_trig, 0);
            if (bus.trigger) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL trigger_word: got trigger 0x%0h expected no trigger", bus.ep_dataout);
                end else begin
                    check("trigger_word", bus.ep_dataout, exp_q.pop_front());
                end
            end
            prev_trig = bus.trigger;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] w);
        bus.cmd_wr  = 1'b1;
        bus.cmd_din = w;
        step();
        bus.cmd_wr  = 1'b0;
    endtask

    task automatic clr();
        bus.cmd_clr = 1'b1;
        step();
        bus.cmd_clr = 1'b0;
    endtask

    task automatic go();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic done_pulse();
        bus.spi_done = 1'b1;
        step();
        bus.spi_done = 1'b0;
    endtask

    task automatic wait_trigger(input int max, output int n);
        n = 0;
        while (!bus.trigger && n < max) begin
            step();
            n++;
        end
        check("wait_trigger_found", bus.trigger, 1);
    endtask

    // ---------------- directed stimulus ----------------
    int  n;
    bit  saw_done;

    initial begin
        rst          = 1'b1;
        bus.cmd_wr   = 1'b0;
        bus.cmd_din  = '0;
        bus.cmd_clr  = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.spi_done = 1'b0;
        step(2);

        // Reset state
        check("rst_trigger", bus.trigger, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ep_dataout", bus.ep_dataout, 0);
        check("rst_cmd_count", bus.cmd_count, 0);
        check("rst_errs", {bus.timeout_err, bus.wr_err, bus.seq_done}, 0);
        rst = 1'b0;
        cmp_en = 1;
        step();

        // Control word then data word; gap then wait for spi_done
        wr(32'h80000051);
        wr(32'h40000001);
        check("load2_count", bus.cmd_count, 2);
        exp_q.push_back(32'h80000051);
        exp_q.push_back(32'h40000001);
        go();
        check("first_trigger", bus.trigger, 1);
        check("first_word", bus.ep_dataout, 32'h80000051);
        check("busy_on_issue", bus.busy, 1);
        step();
        wait_trigger(20, n);
        check("gap_cycles", n, 3);
        check("second_word", bus.ep_dataout, 32'h40000001);
        step(50);
        done_pulse();
        check("seq_done_after_spi_done", bus.seq_done, 1);
        step();
        check("seq_done_one_cycle", bus.seq_done, 0);
        check("busy_after_done", bus.busy, 0);

        // Overflow and clear
        clr();
        for (int i = 0; i < DEPTH; i++) wr(32'h1000 + i);
        check("full_count", bus.cmd_count, 16);
        check("full_wr_err_clear", bus.wr_err, 0);
        wr(32'hdeadbeef);
        check("overflow_count", bus.cmd_count, 16);
        check("overflow_wr_err", bus.wr_err, 1);
        clr();
        check("clr_count", bus.cmd_count, 0);
        check("clr_wr_err", bus.wr_err, 0);

        // Timeout with spi_done held low
        wr(32'h40008aa5);
        exp_q.push_back(32'h40008aa5);
        go();
        check("tmo_trigger_word", bus.ep_dataout, 32'h40008aa5);
        n = 0;
        saw_done = 0;
        while (!bus.timeout_err && n < 1100) begin
            step();
            n++;
            if (bus.seq_done) saw_done = 1;
        end
        check("timeout_latency", n, 1025);
        check("timeout_err_set", bus.timeout_err, 1);
        check("timeout_busy", bus.busy, 0);
        check("timeout_no_seq_done", saw_done, 0);

        // Abort during the wait of entry 2, then replay from entry 0
        clr();
        wr(32'h40000a00);
        wr(32'h40000b01);
        wr(32'h40000c02);
        exp_q.push_back(32'h40000a00);
        exp_q.push_back(32'h40000b01);
        exp_q.push_back(32'h40000c02);
        go();
        check("abort_e0_word", bus.ep_dataout, 32'h40000a00);
        check("start_clears_timeout", bus.timeout_err, 0);
        step();
        done_pulse();
        check("abort_e1_word", bus.ep_dataout, 32'h40000b01);
        step();
        done_pulse();
        check("abort_e2_word", bus.ep_dataout, 32'h40000c02);
        step();
        wr(32'h00001234);
        check("busy_wr_err", bus.wr_err, 1);
        check("busy_wr_count", bus.cmd_count, 3);
        step(2);
        bus.abort    = 1'b1;
        bus.spi_done = 1'b1;
        step();
        bus.abort    = 1'b0;
        bus.spi_done = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_no_seq_done", bus.seq_done, 0);
        exp_q.push_back(32'h40000a00);
        exp_q.push_back(32'h40000b01);
        exp_q.push_back(32'h40000c02);
        go();
        check("replay_first_word", bus.ep_dataout, 32'h40000a00);
        step();
        done_pulse();
        step();
        done_pulse();
        step();
        done_pulse();
        check("replay_seq_done", bus.seq_done, 1);
        step();
        check("replay_idle", bus.busy, 0);

        // Empty start, start+abort in IDLE, start while busy
        clr();
        go();
        check("empty_seq_done", bus.seq_done, 1);
        check("empty_no_trigger", bus.trigger, 0);
        step();
        check("empty_seq_done_pulse", bus.seq_done, 0);
        wr(32'h00000123);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_idle", bus.busy, 0);
        step(3);
        exp_q.push_back(32'h00000123);
        go();
        step();
        go();
        step(8);
        check("start_while_busy_ignored", bus.busy, 0);

        // Reset in the middle of a gap
        clr();
        wr(32'h80000011);
        wr(32'h80000022);
        exp_q.push_back(32'h80000011);
        go();
        step(2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_ep", bus.ep_dataout, 0);
        check("async_rst_count", bus.cmd_count, 0);
        check("async_rst_flags", {bus.trigger, bus.seq_done, bus.timeout_err, bus.wr_err}, 0);
        step();
        rst = 1'b0;
        step(2);
        check("post_rst_count", bus.cmd_count, 0);
        check("post_rst_busy", bus.busy, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
